// File: rtl/gate_response_checker.sv
// gate_response_checker
//   Self-test controller for the two-input logic-gate trainer board. It walks
//   the four (a,b) vectors onto the gate array, lets each one settle, samples
//   the eight gate outputs against the golden truth table and accumulates a
//   sticky per-gate failure mask. When the sweep ends it reports pass/fail.
//
// Parameters
//   SETTLE_CYCLES  clocks ab_out is held before each sample (1..255)
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   start      in   1  begin a sweep; honoured only in IDLE or DONE
//   ab_out     out  2  stimulus to the gate array: [0]=a, [1]=b
//   resp_in    in   8  gate outputs: AND,OR,XOR,NAND,NOR,XNOR,~a,~b (bit 0..7)
//   busy       out  1  sweep in progress (SETTLE or SAMPLE)
//   done       out  1  sweep finished, results held
//   pass       out  1  done with an all-zero fail_mask
//   fail_mask  out  8  sticky OR of per-gate mismatches over the sweep
//   err_cnt    out  6  total mismatching bits (only with ERR_CNT_EN)
//   vec_idx    out  2  index of the vector currently driven
//
// Build option
//   ERR_CNT_EN  when defined, adds the err_cnt mismatch-bit counter port.

module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] ab_out,
  input  logic [7:0] resp_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
`ifdef ERR_CNT_EN
  output logic [5:0] err_cnt,
`endif
  output logic [1:0] vec_idx
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Counter counts down to zero, so SETTLE spans exactly SETTLE_CYCLES clocks.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  // Golden gate-array response for each stimulus vector.
  function automatic logic [7:0] exp_resp(input logic [1:0] idx);
    logic [7:0] r;
    case (idx)
      2'd0:    r = 8'hF8;
      2'd1:    r = 8'h8E;
      2'd2:    r = 8'h4E;
      2'd3:    r = 8'h23;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

`ifdef ERR_CNT_EN
  // Number of set bits in a mismatch vector.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction
`endif

  logic [1:0] state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [1:0] vec_r, vec_s;
  logic [7:0] mask_r, mask_s;
  logic [7:0] miss_s;
  logic       busy_r, done_r, pass_r;
  logic [1:0] ab_r;
`ifdef ERR_CNT_EN
  logic [5:0] err_r, err_s;
`endif

  // Next-state and datapath update for the sweep FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    vec_s   = vec_r;
    mask_s  = mask_r;
    miss_s  = resp_in ^ exp_resp(vec_r);
`ifdef ERR_CNT_EN
    err_s   = err_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_SETTLE;
          cnt_s   = SETTLE_LOAD;
          vec_s   = 2'd0;
          mask_s  = 8'h00;
`ifdef ERR_CNT_EN
          err_s   = 6'd0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == 8'd0) begin
          state_s = ST_SAMPLE;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ST_SAMPLE: begin
        mask_s = mask_r | miss_s;
`ifdef ERR_CNT_EN
        err_s  = err_r + {2'b00, popcount8(miss_s)};
`endif
        if (vec_r == 2'd3) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SETTLE;
          vec_s   = vec_r + 2'd1;
          cnt_s   = SETTLE_LOAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State registers; flags are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      vec_r   <= 2'd0;
      ab_r    <= 2'd0;
      mask_r  <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
`ifdef ERR_CNT_EN
      err_r   <= 6'd0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      vec_r   <= vec_s;
      ab_r    <= vec_s;
      mask_r  <= mask_s;
      busy_r  <= (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
      done_r  <= (state_s == ST_DONE);
      pass_r  <= (state_s == ST_DONE) && (mask_s == 8'h00);
`ifdef ERR_CNT_EN
      err_r   <= err_s;
`endif
    end
  end

  assign ab_out    = ab_r;
  assign vec_idx   = vec_r;
  assign fail_mask = mask_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
`ifdef ERR_CNT_EN
  assign err_cnt   = err_r;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker. Edges are numbered from 1 at the
// edge that samples start; outputs are sampled 1 time unit after each edge.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst, start, rst1, start1;
  logic [1:0] ab_out, ab1, vec_idx, vec1;
  logic [7:0] resp_in, resp1, fail_mask, mask1;
  logic       busy, done, pass, busy1, done1, pass1;
  int         model_mode;
  int         n_vec = 0;
  int         n_miss = 0;
  int         done_edge;
`ifdef ERR_CNT_EN
  logic [5:0] err_cnt, err1;
`endif

  always #5 clk = ~clk;

  // Reference gate array built from the gate definitions, plus fault modes.
  function automatic logic [7:0] gates(input logic [1:0] ab, input int mode);
    logic a, b;
    logic [7:0] r;
    a = ab[0];
    b = ab[1];
    r = {~b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
    case (mode)
      1:       r = 8'h00;
      2:       r = r ^ 8'h40;
      3:       r = r & 8'hFE;
      default: r = r;
    endcase
    return r;
  endfunction

  assign resp_in = gates(ab_out, model_mode);
  assign resp1   = gates(ab1, 0);

  gate_response_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .ab_out(ab_out), .resp_in(resp_in),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
`ifdef ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .vec_idx(vec_idx)
  );

  gate_response_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .ab_out(ab1), .resp_in(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1),
`ifdef ERR_CNT_EN
    .err_cnt(err1),
`endif
    .vec_idx(vec1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done starting from edge 'from'; reports the edge or -1 on timeout.
  task automatic wait_done(input int from, output int edge_no);
    edge_no = -1;
    for (int e = from; e <= 60; e++) begin
      tick();
      if (done === 1'b1) begin
        edge_no = e;
        break;
      end
    end
  endtask

  // Pulse start in IDLE/DONE, check the start edge, then wait for completion.
  task automatic run_sweep(input int mode, input string tag, output int edge_no);
    model_mode = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_pass_drop"}, {31'd0, pass}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_ab0"}, {30'd0, ab_out}, 32'd0);
    wait_done(2, edge_no);
    check({tag, "_latency"}, edge_no, 32'd21);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rst1 = 1'b1; start1 = 1'b0; model_mode = 0;
    tick();
    tick();
    check("rst_ab", {30'd0, ab_out}, 32'd0);
    check("rst_vec", {30'd0, vec_idx}, 32'd0);
    check("rst_mask", {24'd0, fail_mask}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    rst = 1'b0;
    tick();

    // Correct gate array
    run_sweep(0, "good", done_edge);
    check("good_pass", {31'd0, pass}, 32'd1);
    check("good_mask", {24'd0, fail_mask}, 32'h00);
    check("good_ab", {30'd0, ab_out}, 32'd3);
    check("good_busy", {31'd0, busy}, 32'd0);
`ifdef ERR_CNT_EN
    check("good_err", {26'd0, err_cnt}, 32'd0);
`endif

    // All outputs stuck low (restart from DONE)
    run_sweep(1, "zero", done_edge);
    check("zero_mask", {24'd0, fail_mask}, 32'hFF);
    check("zero_pass", {31'd0, pass}, 32'd0);
`ifdef ERR_CNT_EN
    check("zero_err", {26'd0, err_cnt}, 32'd16);
`endif

    // ~a output inverted
    run_sweep(2, "inv6", done_edge);
    check("inv6_mask", {24'd0, fail_mask}, 32'h40);
    check("inv6_pass", {31'd0, pass}, 32'd0);
`ifdef ERR_CNT_EN
    check("inv6_err", {26'd0, err_cnt}, 32'd4);
`endif

    // AND stuck at 0: only v3 disagrees
    run_sweep(3, "and0", done_edge);
    check("and0_mask", {24'd0, fail_mask}, 32'h01);
`ifdef ERR_CNT_EN
    check("and0_err", {26'd0, err_cnt}, 32'd1);
`endif

    // start re-pulsed during SETTLE of v1 is ignored
    model_mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("ign_vec_before", {30'd0, vec_idx}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_vec_after", {30'd0, vec_idx}, 32'd1);
    check("ign_busy", {31'd0, busy}, 32'd1);
    wait_done(9, done_edge);
    check("ign_latency", done_edge, 32'd21);
    check("ign_mask", {24'd0, fail_mask}, 32'h40);
`ifdef ERR_CNT_EN
    check("ign_err", {26'd0, err_cnt}, 32'd4);
`endif

    // rst during SETTLE of v2
    model_mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("mid_vec", {30'd0, vec_idx}, 32'd2);
    check("mid_mask", {24'd0, fail_mask}, 32'hFE);
    rst = 1'b1;
    tick();
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_ab", {30'd0, ab_out}, 32'd0);
    check("rstmid_mask", {24'd0, fail_mask}, 32'h00);
    check("rstmid_vec", {30'd0, vec_idx}, 32'd0);
    start = 1'b1;
    tick();
    check("rststart_busy", {31'd0, busy}, 32'd1 - 32'd1);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("rststart_idle", {31'd0, busy}, 32'd0);

    // SETTLE_CYCLES=1, start held high: back-to-back sweeps with period 9
    rst1 = 1'b0;
    start1 = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      int p;
      tick();
      p = (e - 1) % 9;
      check($sformatf("b2b_done_e%0d", e), {31'd0, done1}, (p == 8) ? 32'd1 : 32'd0);
      check($sformatf("b2b_ab_e%0d", e), {30'd0, ab1}, (p == 8) ? 32'd3 : p / 2);
      if (p == 8) begin
        check($sformatf("b2b_pass_e%0d", e), {31'd0, pass1}, 32'd1);
      end
    end
    start1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
